// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU sequencer slice.
//   alu_op_t         request opcodes (000 and 111 are illegal)
//   alu_seq_state_t  sequencer FSM states
//   ALU_WIDTH        default operand/result width
package alu_seq_pkg;

    localparam int unsigned ALU_WIDTH = 16;

    typedef enum logic [2:0] {
        OP_ASSIGN = 3'b001,
        OP_ADD    = 3'b010,
        OP_SUB    = 3'b011,
        OP_MULT   = 3'b100,
        OP_DIV    = 3'b101,
        OP_SHL    = 3'b110
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIV,
        ST_RESP
    } alu_seq_state_t;

endpackage

// File: rtl/alu_sequencer_if.sv
// Request/response bundle between an ALU client (master) and alu_sequencer (slave).
//   ReqValid/ReqReady/ReqOp/ReqA/ReqB   request channel
//   RspValid/RspReady                   response handshake
//   RspOut1/RspOut2/RspZero/RspErr      response payload
//   Abort                               only present when ALU_SEQ_ABORT_EN is defined
interface alu_sequencer_if
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH,
    parameter int unsigned OP_W  = 3
);

    logic             ReqValid;
    logic             ReqReady;
    logic [OP_W-1:0]  ReqOp;
    logic [WIDTH-1:0] ReqA;
    logic [WIDTH-1:0] ReqB;
    logic             RspValid;
    logic             RspReady;
    logic [WIDTH-1:0] RspOut1;
    logic [WIDTH-1:0] RspOut2;
    logic             RspZero;
    logic             RspErr;
`ifdef ALU_SEQ_ABORT_EN
    logic             Abort;
`endif

    modport master (
`ifdef ALU_SEQ_ABORT_EN
        output Abort,
`endif
        output ReqValid, ReqOp, ReqA, ReqB, RspReady,
        input  ReqReady, RspValid, RspOut1, RspOut2, RspZero, RspErr
    );

    modport slave (
`ifdef ALU_SEQ_ABORT_EN
        input  Abort,
`endif
        input  ReqValid, ReqOp, ReqA, ReqB, RspReady,
        output ReqReady, RspValid, RspOut1, RspOut2, RspZero, RspErr
    );

endinterface

// File: rtl/alu_div_step.sv
// One combinational restoring-division step.
//   rem           partial remainder in (always < divisor)
//   dividend      remaining dividend bits, MSB consumed this step
//   divisor       divisor (non-zero)
//   rem_next      partial remainder out
//   dividend_next dividend shifted left by one
//   q_bit         quotient bit produced by this step
module alu_div_step #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] dividend_next,
    output logic             q_bit
);

    // One extra bit: the shifted remainder can reach 2*divisor-1.
    logic [WIDTH:0] trial;
    logic [WIDTH:0] diff;

    assign trial         = {rem, dividend[WIDTH-1]};
    assign diff          = trial - {1'b0, divisor};
    assign dividend_next = dividend << 1;

    always_comb begin
        if (trial >= {1'b0, divisor}) begin
            q_bit    = 1'b1;
            rem_next = diff[WIDTH-1:0];
        end else begin
            q_bit    = 1'b0;
            rem_next = trial[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle ALU front end: single-cycle ops answer one cycle after accept,
// DIV runs WIDTH restoring steps. Results are held until the response handshakes.
//   Clk      rising-edge clock
//   Reset_n  asynchronous active-low reset
//   bus      alu_sequencer_if slave modport (request/response channels)
// Optional feature: define ALU_SEQ_ABORT_EN to honour bus.Abort while dividing.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH,
    parameter int unsigned OP_W  = 3
) (
    input  logic        Clk,
    input  logic        Reset_n,
    alu_sequencer_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    alu_seq_state_t   state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem, dvd, dsr, quo, quo_nxt;
    logic [WIDTH-1:0] out1, out2;
    logic             err;

    logic [OP_W-1:0]  op;
    logic             accept, div_start, last_step, abort_div;

    logic [WIDTH-1:0] fast_out1, fast_out2;
    logic             fast_err;
    logic [WIDTH:0]   sum, diff;
    logic [2*WIDTH-1:0] prod;

    logic [WIDTH-1:0] step_rem, step_dvd;
    logic             step_q;

    assign op        = bus.ReqOp;
    assign accept    = bus.ReqValid && (state == ST_IDLE);
    assign div_start = accept && (op == OP_DIV) && (bus.ReqB != '0);
    assign last_step = (state == ST_DIV) && (cnt == CNT_W'(WIDTH - 1));

`ifdef ALU_SEQ_ABORT_EN
    assign abort_div = (state == ST_DIV) && bus.Abort;
`else
    assign abort_div = 1'b0;
`endif

    alu_div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem           (rem),
        .dividend      (dvd),
        .divisor       (dsr),
        .rem_next      (step_rem),
        .dividend_next (step_dvd),
        .q_bit         (step_q)
    );

    assign quo_nxt = (quo << 1) | {{(WIDTH-1){1'b0}}, step_q};

    // Single-cycle results; the DIV arm only matters for a zero divisor.
    assign sum  = {1'b0, bus.ReqA} + {1'b0, bus.ReqB};
    assign diff = {1'b0, bus.ReqA} - {1'b0, bus.ReqB};
    assign prod = {{WIDTH{1'b0}}, bus.ReqA} * {{WIDTH{1'b0}}, bus.ReqB};

    always_comb begin
        fast_out1 = '0;
        fast_out2 = '0;
        fast_err  = 1'b0;
        case (op)
            OP_ASSIGN: fast_out1 = bus.ReqB;
            OP_ADD: begin
                fast_out1 = sum[WIDTH-1:0];
                fast_out2 = {{(WIDTH-1){1'b0}}, sum[WIDTH]};
            end
            OP_SUB: begin
                fast_out1 = diff[WIDTH-1:0];
                fast_out2 = {{(WIDTH-1){1'b0}}, diff[WIDTH]};
            end
            OP_MULT: begin
                fast_out1 = prod[WIDTH-1:0];
                fast_out2 = prod[2*WIDTH-1:WIDTH];
            end
            OP_DIV: begin
                fast_out1 = '1;
                fast_out2 = bus.ReqA;
                fast_err  = 1'b1;
            end
            OP_SHL: fast_out1 = (32'(bus.ReqB) >= WIDTH) ? '0 : (bus.ReqA << bus.ReqB);
            default: fast_err = 1'b1;
        endcase
    end

    // FSM: state register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (div_start)   state_nxt = ST_DIV;
                else if (accept) state_nxt = ST_RESP;
            end
            ST_DIV: begin
                if (abort_div)      state_nxt = ST_IDLE;
                else if (last_step) state_nxt = ST_RESP;
            end
            ST_RESP: if (bus.RspReady) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        bus.ReqReady = (state == ST_IDLE);
        bus.RspValid = (state == ST_RESP);
        bus.RspOut1  = out1;
        bus.RspOut2  = out2;
        bus.RspZero  = (out1 == '0);
        bus.RspErr   = err;
    end

    // Divider working registers and response registers
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt  <= '0;
            rem  <= '0;
            dvd  <= '0;
            dsr  <= '0;
            quo  <= '0;
            out1 <= '0;
            out2 <= '0;
            err  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (div_start) begin
                        cnt <= '0;
                        rem <= '0;
                        quo <= '0;
                        dvd <= bus.ReqA;
                        dsr <= bus.ReqB;
                    end else if (accept) begin
                        out1 <= fast_out1;
                        out2 <= fast_out2;
                        err  <= fast_err;
                    end
                end
                ST_DIV: begin
                    cnt <= cnt + CNT_W'(1);
                    rem <= step_rem;
                    dvd <= step_dvd;
                    quo <= quo_nxt;
                    if (last_step && !abort_div) begin
                        out1 <= quo_nxt;
                        out2 <= step_rem;
                        err  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: a latency-level behavioural model
// checked against the DUT every cycle, plus directed vectors with literal
// expectations. Define ALU_SEQ_ABORT_EN to include the abort scenarios.
module tb_alu_sequencer;
    import alu_seq_pkg::*;

    localparam int unsigned W = 16;

    logic Clk = 1'b0;
    logic Reset_n;
    always #5 Clk = ~Clk;

    alu_sequencer_if #(.WIDTH(W), .OP_W(3)) bus ();

    alu_sequencer #(.WIDTH(W), .OP_W(3)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [15:0] o1;
        logic [15:0] o2;
        logic        err;
        logic [4:0]  lat;
    } mres_t;

    function automatic mres_t model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        mres_t       r;
        int unsigned wide;
        r     = '0;
        r.lat = 5'd1;
        case (op)
            3'b001: r.o1 = b;
            3'b010: begin
                wide = a + b;
                r.o1 = wide[15:0];
                r.o2 = wide[31:16];
            end
            3'b011: begin
                r.o1 = a - b;
                r.o2 = (a < b) ? 16'd1 : 16'd0;
            end
            3'b100: begin
                wide = a * b;
                r.o1 = wide[15:0];
                r.o2 = wide[31:16];
            end
            3'b101: begin
                if (b == 16'd0) begin
                    r.o1  = 16'hFFFF;
                    r.o2  = a;
                    r.err = 1'b1;
                end else begin
                    r.o1  = a / b;
                    r.o2  = a % b;
                    r.lat = 5'd17;
                end
            end
            3'b110: r.o1 = (b >= 16'd16) ? 16'h0000 : 16'(a << b);
            default: r.err = 1'b1;
        endcase
        return r;
    endfunction

    mres_t       c_res, p_res;
    logic        m_valid;
    int          m_cd;
    logic [15:0] m_o1, m_o2;
    logic        m_err;
    logic        m_abort;

`ifdef ALU_SEQ_ABORT_EN
    assign m_abort = bus.Abort;
`else
    assign m_abort = 1'b0;
`endif

    always_comb c_res = model(bus.ReqOp, bus.ReqA, bus.ReqB);

    // m_cd counts remaining cycles of an in-flight DIV; m_valid = response pending.
    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            m_valid <= 1'b0;
            m_cd    <= 0;
            m_o1    <= '0;
            m_o2    <= '0;
            m_err   <= 1'b0;
        end else if (m_cd > 0) begin
            if (m_abort) begin
                m_cd <= 0;
            end else begin
                m_cd <= m_cd - 1;
                if (m_cd == 1) begin
                    m_valid <= 1'b1;
                    m_o1    <= p_res.o1;
                    m_o2    <= p_res.o2;
                    m_err   <= p_res.err;
                end
            end
        end else if (m_valid) begin
            if (bus.RspReady) m_valid <= 1'b0;
        end else if (bus.ReqValid) begin
            if (c_res.lat == 5'd1) begin
                m_valid <= 1'b1;
                m_o1    <= c_res.o1;
                m_o2    <= c_res.o2;
                m_err   <= c_res.err;
            end else begin
                p_res <= c_res;
                m_cd  <= int'(c_res.lat) - 1;
            end
        end
    end

    // Compare process: every output is meaningful every cycle (results are held).
    always @(negedge Clk) begin
        chk("ReqReady", bus.ReqReady, (!m_valid && m_cd == 0));
        chk("RspValid", bus.RspValid, m_valid);
        chk("RspOut1",  bus.RspOut1,  m_o1);
        chk("RspOut2",  bus.RspOut2,  m_o2);
        chk("RspZero",  bus.RspZero,  (m_o1 == 16'd0));
        chk("RspErr",   bus.RspErr,   m_err);
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        int n = 0;
        @(negedge Clk);
        bus.ReqValid = 1'b1;
        bus.ReqOp    = op;
        bus.ReqA     = a;
        bus.ReqB     = b;
        while (!bus.ReqReady && n < 200) begin
            @(negedge Clk);
            n++;
        end
        if (n >= 200) chk("accept timeout", 32'(n), 32'd0);
        @(posedge Clk);
        #1;
        bus.ReqValid = 1'b0;
        bus.ReqOp    = 3'($urandom);
        bus.ReqA     = 16'($urandom);
        bus.ReqB     = 16'($urandom);
    endtask

    task automatic wait_rsp(output int lat);
        lat = 1;
        @(negedge Clk);
        while (!bus.RspValid && lat < 100) begin
            @(negedge Clk);
            lat++;
        end
    endtask

    task automatic ack(input int hold);
        repeat (hold) @(negedge Clk);
        @(negedge Clk);
        bus.RspReady = 1'b1;
        @(posedge Clk);
        #1;
        bus.RspReady = 1'b0;
    endtask

    task automatic run_vec(input string name, input logic [2:0] op, input logic [15:0] a,
                           input logic [15:0] b, input logic [15:0] e1, input logic [15:0] e2,
                           input logic eerr, input int elat);
        int lat;
        send(op, a, b);
        wait_rsp(lat);
        chk({name, " latency"}, 32'(lat), 32'(elat));
        chk({name, " out1"}, bus.RspOut1, e1);
        chk({name, " out2"}, bus.RspOut2, e2);
        chk({name, " err"},  bus.RspErr,  eerr);
        chk({name, " zero"}, bus.RspZero, (e1 == 16'd0));
        ack(0);
    endtask

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [15:0] a, b, o1, o2;
        logic        err;
        int          lat;
    } vec_t;

    vec_t vecs [17];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout at %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;

        vecs[0]  = '{"assign",    OP_ASSIGN, 16'h1234, 16'hBEEF, 16'hBEEF, 16'h0000, 1'b0, 1};
        vecs[1]  = '{"add wrap",  OP_ADD,    16'hFFFF, 16'h0001, 16'h0000, 16'h0001, 1'b0, 1};
        vecs[2]  = '{"add",       OP_ADD,    16'h1234, 16'h1111, 16'h2345, 16'h0000, 1'b0, 1};
        vecs[3]  = '{"sub borrow",OP_SUB,    16'h0003, 16'h0005, 16'hFFFE, 16'h0001, 1'b0, 1};
        vecs[4]  = '{"sub",       OP_SUB,    16'h0005, 16'h0003, 16'h0002, 16'h0000, 1'b0, 1};
        vecs[5]  = '{"mult max",  OP_MULT,   16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b0, 1};
        vecs[6]  = '{"shl 4",     OP_SHL,    16'h0001, 16'h0004, 16'h0010, 16'h0000, 1'b0, 1};
        vecs[7]  = '{"shl 15",    OP_SHL,    16'hFFFF, 16'h000F, 16'h8000, 16'h0000, 1'b0, 1};
        vecs[8]  = '{"shl 16",    OP_SHL,    16'h8001, 16'h0010, 16'h0000, 16'h0000, 1'b0, 1};
        vecs[9]  = '{"shl big",   OP_SHL,    16'h0001, 16'h0100, 16'h0000, 16'h0000, 1'b0, 1};
        vecs[10] = '{"div 100/7", OP_DIV,    16'd100,  16'd7,    16'd14,   16'd2,    1'b0, 17};
        vecs[11] = '{"div /1",    OP_DIV,    16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 17};
        vecs[12] = '{"div /3",    OP_DIV,    16'hFFFF, 16'h0003, 16'h5555, 16'h0000, 1'b0, 17};
        vecs[13] = '{"div small", OP_DIV,    16'd5,    16'd9,    16'd0,    16'd5,    1'b0, 17};
        vecs[14] = '{"div by 0",  OP_DIV,    16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1, 1};
        vecs[15] = '{"op 000",    3'b000,    16'h1111, 16'h2222, 16'h0000, 16'h0000, 1'b1, 1};
        vecs[16] = '{"op 111",    3'b111,    16'h3333, 16'h4444, 16'h0000, 16'h0000, 1'b1, 1};

        Reset_n      = 1'b0;
        bus.ReqValid = 1'b0;
        bus.ReqOp    = '0;
        bus.ReqA     = '0;
        bus.ReqB     = '0;
        bus.RspReady = 1'b0;
`ifdef ALU_SEQ_ABORT_EN
        bus.Abort    = 1'b0;
`endif
        repeat (3) @(negedge Clk);
        chk("reset ReqReady", bus.ReqReady, 1'b1);
        chk("reset RspValid", bus.RspValid, 1'b0);
        chk("reset RspOut1",  bus.RspOut1,  16'h0000);
        chk("reset RspZero",  bus.RspZero,  1'b1);
        chk("reset RspErr",   bus.RspErr,   1'b0);
        Reset_n = 1'b1;

        foreach (vecs[i])
            run_vec(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b,
                    vecs[i].o1, vecs[i].o2, vecs[i].err, vecs[i].lat);

        // Back-pressure: response held, queued request waits for the handshake.
        send(OP_MULT, 16'h0100, 16'h0100);
        wait_rsp(lat);
        chk("mult latency", 32'(lat), 32'd1);
        bus.ReqValid = 1'b1;
        bus.ReqOp    = OP_ASSIGN;
        bus.ReqA     = 16'h0000;
        bus.ReqB     = 16'h0055;
        repeat (5) begin
            chk("mult hold out1",     bus.RspOut1,  16'h0000);
            chk("mult hold out2",     bus.RspOut2,  16'h0001);
            chk("mult hold ReqReady", bus.ReqReady, 1'b0);
            chk("mult hold RspValid", bus.RspValid, 1'b1);
            @(negedge Clk);
        end
        bus.RspReady = 1'b1;
        @(posedge Clk);
        #1;
        bus.RspReady = 1'b0;
        @(negedge Clk);
        chk("queued ReqReady after handshake", bus.ReqReady, 1'b1);
        chk("queued RspValid after handshake", bus.RspValid, 1'b0);
        @(posedge Clk);
        #1;
        bus.ReqValid = 1'b0;
        @(negedge Clk);
        chk("queued RspValid", bus.RspValid, 1'b1);
        chk("queued out1",     bus.RspOut1,  16'h0055);
        ack(0);

        // Reset in the middle of a divide: no response, reset values at once.
        send(OP_DIV, 16'd100, 16'd7);
        repeat (8) @(posedge Clk);
        #1;
        Reset_n = 1'b0;
        #1;
        chk("midreset ReqReady", bus.ReqReady, 1'b1);
        chk("midreset RspValid", bus.RspValid, 1'b0);
        chk("midreset RspOut1",  bus.RspOut1,  16'h0000);
        chk("midreset RspOut2",  bus.RspOut2,  16'h0000);
        chk("midreset RspZero",  bus.RspZero,  1'b1);
        chk("midreset RspErr",   bus.RspErr,   1'b0);
        @(negedge Clk);
        Reset_n = 1'b1;
        run_vec("sub after reset", OP_SUB, 16'd3, 16'd5, 16'hFFFE, 16'h0001, 1'b0, 1);

`ifdef ALU_SEQ_ABORT_EN
        send(OP_DIV, 16'hFFFF, 16'd3);
        repeat (5) @(negedge Clk);
        bus.Abort = 1'b1;
        @(posedge Clk);
        #1;
        bus.Abort = 1'b0;
        @(negedge Clk);
        chk("abort ReqReady", bus.ReqReady, 1'b1);
        chk("abort RspValid", bus.RspValid, 1'b0);
        repeat (20) @(negedge Clk);
        chk("abort no late rsp", bus.RspValid, 1'b0);
        run_vec("assign after abort", OP_ASSIGN, 16'h0000, 16'h00AA, 16'h00AA, 16'h0000, 1'b0, 1);

        // Abort is ignored outside DIV.
        bus.Abort = 1'b1;
        run_vec("assign under abort", OP_ASSIGN, 16'h0000, 16'h1357, 16'h1357, 16'h0000, 1'b0, 1);
        bus.Abort = 1'b0;
        send(OP_ADD, 16'd1, 16'd2);
        wait_rsp(lat);
        bus.Abort = 1'b1;
        repeat (3) @(negedge Clk);
        chk("abort in RESP RspValid", bus.RspValid, 1'b1);
        chk("abort in RESP out1",     bus.RspOut1,  16'd3);
        bus.Abort = 1'b0;
        ack(0);
`endif

        repeat (3) @(negedge Clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
